sub_table_encryptor: RTL and testbench

Encryption end of the substitution-table cipher link. The block loads the same 12-byte key as the decryptor, validates it sequentially, and maps each plaintext letter onto a two-letter ciphertext pair, plus an upper/lower case flag. It sits upstream of the decryptor: its output bus can be wired directly to the decryptor's ciphertext input.

---
 rtl/sub_table_encryptor_if.sv | 28 ++
 rtl/sub_table_encryptor.sv | 169 ++++++++++++++++
 tb/tb_sub_table_encryptor.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_table_encryptor_if.sv
// Handshake and key-load bus of the substitution-table encryptor.
// master drives key/plaintext and consumes ciphertext; slave is the encryptor.
interface sub_table_encryptor_if;
    logic [7:0]  key_byte;
    logic [3:0]  byte_pos;
    logic        key_byte_val;
    logic        ptxt_valid;
    logic [7:0]  plaintext;
    logic        ptxt_ready;
    logic        ctxt_valid;
    logic        ctxt_ready;
    logic [15:0] ciphertext;
    logic        upper_lower;
    logic        error_flag_key;
    logic        error_flag_plaintext;

    modport master (
        output key_byte, byte_pos, key_byte_val, ptxt_valid, plaintext, ctxt_ready,
        input  ptxt_ready, ctxt_valid, ciphertext, upper_lower,
               error_flag_key, error_flag_plaintext
    );

    modport slave (
        input  key_byte, byte_pos, key_byte_val, ptxt_valid, plaintext, ctxt_ready,
        output ptxt_ready, ctxt_valid, ciphertext, upper_lower,
               error_flag_key, error_flag_plaintext
    );
endinterface

// File: rtl/sub_table_encryptor.sv
// Substitution-table cipher encryptor: letter -> {key[p/6], key[6 + p%6]} pair.
// Define SUB_TABLE_ENC_KEY_CHECK_EN to enable the sequential key validation (CHECK/KEY_ERR).
module sub_table_encryptor #(
    parameter int KEY_LEN = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sub_table_encryptor_if.slave bus
);

`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
    typedef enum logic [2:0] {EMPTY, LOAD, CHECK, READY, KEY_ERR} state_t;
`else
    typedef enum logic [2:0] {EMPTY, LOAD, READY} state_t;
`endif

    state_t      state_reg;
    logic [7:0]  key_reg [KEY_LEN];
    logic        ctxt_valid_reg;
    logic [15:0] ciphertext_reg;
    logic        upper_lower_reg;
    logic        err_ptxt_reg;

    logic        accept_state;
    logic        accept;
    logic        is_upper;
    logic        is_lower;
    logic [4:0]  letter_idx;
    logic [3:0]  row_idx;
    logic [3:0]  col_sel;
    logic [15:0] enc_word;

    genvar gi;
    generate
        for (gi = 0; gi < KEY_LEN; gi++) begin : g_key
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    key_reg[gi] <= 8'h00;
                else if (bus.key_byte_val && bus.byte_pos == 4'(gi))
                    key_reg[gi] <= bus.key_byte;
            end
        end
    endgenerate

    always_comb begin
        is_upper   = (bus.plaintext >= 8'h41) && (bus.plaintext <= 8'h5A);
        is_lower   = (bus.plaintext >= 8'h61) && (bus.plaintext <= 8'h7A);
        letter_idx = '0;
        if (is_upper)
            letter_idx = 5'(bus.plaintext - 8'h41);
        else if (is_lower)
            letter_idx = 5'(bus.plaintext - 8'h61);
        row_idx  = 4'(letter_idx / 5'd6);
        col_sel  = 4'(letter_idx % 5'd6) + 4'd6;
        enc_word = {key_reg[row_idx], key_reg[col_sel]};
    end

`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
    logic [3:0]  chk_idx_reg;
    logic [25:0] seen_reg;
    logic        chk_bad_reg;
    logic        err_key_reg;
    logic [7:0]  chk_byte;
    logic        chk_in_range;
    logic [4:0]  chk_letter;
    logic        chk_bad_next;

    // One key byte per cycle: out-of-range or already-seen letters poison the key.
    always_comb begin
        chk_byte     = key_reg[chk_idx_reg];
        chk_in_range = (chk_byte >= 8'h61) && (chk_byte <= 8'h7A);
        chk_letter   = 5'(chk_byte - 8'h61);
        chk_bad_next = chk_bad_reg || !chk_in_range || (chk_in_range && seen_reg[chk_letter]);
    end

    assign accept_state       = (state_reg == READY) || (state_reg == KEY_ERR);
    assign bus.error_flag_key = err_key_reg || (state_reg == KEY_ERR);
`else
    assign accept_state       = (state_reg == READY);
    assign bus.error_flag_key = 1'b0;
`endif

    assign bus.ptxt_ready = accept_state && (!ctxt_valid_reg || bus.ctxt_ready);
    assign accept         = bus.ptxt_valid && bus.ptxt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= EMPTY;
            ctxt_valid_reg  <= 1'b0;
            ciphertext_reg  <= 16'h0000;
            upper_lower_reg <= 1'b0;
            err_ptxt_reg    <= 1'b0;
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
            chk_idx_reg     <= 4'd0;
            seen_reg        <= 26'd0;
            chk_bad_reg     <= 1'b0;
            err_key_reg     <= 1'b0;
`endif
        end else if (bus.key_byte_val) begin
            // A key write discards any pending word and restarts validation.
            state_reg       <= LOAD;
            ctxt_valid_reg  <= 1'b0;
            ciphertext_reg  <= 16'h0000;
            upper_lower_reg <= 1'b0;
            err_ptxt_reg    <= 1'b0;
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
            err_key_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
                LOAD: begin
                    state_reg   <= CHECK;
                    chk_idx_reg <= 4'd0;
                    seen_reg    <= 26'd0;
                    chk_bad_reg <= 1'b0;
                end
                CHECK: begin
                    chk_bad_reg <= chk_bad_next;
                    if (chk_in_range)
                        seen_reg <= seen_reg | (26'd1 << chk_letter);
                    if (chk_idx_reg == 4'(KEY_LEN - 1))
                        state_reg <= chk_bad_next ? KEY_ERR : READY;
                    else
                        chk_idx_reg <= chk_idx_reg + 4'd1;
                end
`else
                LOAD: state_reg <= READY;
`endif
                default: ;
            endcase

            if (accept) begin
                ctxt_valid_reg <= 1'b1;
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
                if (state_reg == KEY_ERR) begin
                    ciphertext_reg  <= 16'h0000;
                    upper_lower_reg <= 1'b0;
                    err_ptxt_reg    <= 1'b0;
                    err_key_reg     <= 1'b1;
                end else
`endif
                if (is_upper || is_lower) begin
                    ciphertext_reg  <= enc_word;
                    upper_lower_reg <= is_upper;
                    err_ptxt_reg    <= 1'b0;
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
                    err_key_reg     <= 1'b0;
`endif
                end else begin
                    ciphertext_reg  <= 16'h0000;
                    upper_lower_reg <= 1'b0;
                    err_ptxt_reg    <= 1'b1;
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
                    err_key_reg     <= 1'b0;
`endif
                end
            end else if (ctxt_valid_reg && bus.ctxt_ready) begin
                ctxt_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.ctxt_valid           = ctxt_valid_reg;
    assign bus.ciphertext           = ciphertext_reg;
    assign bus.upper_lower          = upper_lower_reg;
    assign bus.error_flag_plaintext = err_ptxt_reg;

endmodule

// File: tb/tb_sub_table_encryptor.sv
// Directed self-checking bench for sub_table_encryptor, default and key-check builds.
module tb_sub_table_encryptor;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sub_table_encryptor_if bus ();

    sub_table_encryptor #(.KEY_LEN(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
    localparam int KEY_LAT = 13;
`else
    localparam int KEY_LAT = 1;
`endif

    function automatic logic [15:0] pair(input logic [7:0] r, input logic [7:0] c);
        return {r, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input string k);
        for (int i = 0; i < 12; i++) begin
            bus.key_byte_val = 1'b1;
            bus.byte_pos     = 4'(i);
            bus.key_byte     = k[i];
            tick();
        end
        bus.key_byte_val = 1'b0;
    endtask

    // Counts edges until ptxt_ready rises; -1 if the bound expires.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ptxt_ready && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!bus.ptxt_ready) cycles = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({bus.ptxt_ready, bus.ctxt_valid, bus.ciphertext, bus.upper_lower,
             bus.error_flag_key, bus.error_flag_plaintext} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b ct=%h ul=%b efk=%b efp=%b, need all 0",
                     bus.ptxt_ready, bus.ctxt_valid, bus.ciphertext, bus.upper_lower,
                     bus.error_flag_key, bus.error_flag_plaintext);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if (bus.ptxt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_empty_not_ready: got %b need 0", bus.ptxt_ready);
        end
        $display("reset: ready=%b valid=%b", bus.ptxt_ready, bus.ctxt_valid);
    endtask

    task automatic test_key_latency();
        int lat;
        load_key("abcdefghijkl");
        n_checks++;
        if (bus.ptxt_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_not_ready: got %b need 0", bus.ptxt_ready);
        end
        wait_ready(lat);
        n_checks++;
        if (lat != KEY_LAT) begin
            n_fail++;
            $display("FAIL key_latency: got %0d edges need %0d", lat, KEY_LAT);
        end
        $display("key abcdefghijkl: ready after %0d edges", lat);
    endtask

    task automatic test_upper();
        bus.ctxt_ready = 1'b1;
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "H";
        tick();
        bus.ptxt_valid = 1'b0;
        n_checks++;
        if ({bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
             bus.error_flag_plaintext} !== {1'b1, pair("b", "h"), 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL upper_H: got valid=%b ct=%h ul=%b efk=%b efp=%b need 1 %h 1 0 0",
                     bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
                     bus.error_flag_plaintext, pair("b", "h"));
        end
        $display("H -> %h ul=%b", bus.ciphertext, bus.upper_lower);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  chars [3];
        logic [15:0] exp   [3];
        chars[0] = "e"; exp[0] = pair("a", "k");
        chars[1] = "y"; exp[1] = pair("e", "g");
        chars[2] = "z"; exp[2] = pair("e", "h");
        bus.ctxt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ptxt_valid = 1'b1;
            bus.plaintext  = chars[i];
            tick();
            n_checks++;
            if ({bus.ctxt_valid, bus.ciphertext, bus.upper_lower} !== {1'b1, exp[i], 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_%0d: got valid=%b ct=%h ul=%b need 1 %h 0",
                         i, bus.ctxt_valid, bus.ciphertext, bus.upper_lower, exp[i]);
            end
            $display("%c -> %h", chars[i], bus.ciphertext);
        end
        bus.ptxt_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.ctxt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: ctxt_valid got %b need 0", bus.ctxt_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.ctxt_ready = 1'b0;
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "a";
        tick();
        bus.plaintext  = "b";
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({bus.ctxt_valid, bus.ciphertext, bus.ptxt_ready} !== {1'b1, pair("a", "g"), 1'b0}) begin
                n_fail++;
                $display("FAIL hold_%0d: got valid=%b ct=%h ready=%b need 1 %h 0",
                         i, bus.ctxt_valid, bus.ciphertext, bus.ptxt_ready, pair("a", "g"));
            end
            tick();
        end
        bus.ctxt_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.ptxt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b need 1", bus.ptxt_ready);
        end
        tick();
        bus.ptxt_valid = 1'b0;
        n_checks++;
        if ({bus.ctxt_valid, bus.ciphertext} !== {1'b1, pair("a", "h")}) begin
            n_fail++;
            $display("FAIL consume_accept: got valid=%b ct=%h need 1 %h",
                     bus.ctxt_valid, bus.ciphertext, pair("a", "h"));
        end
        $display("backpressure: released, now %h", bus.ciphertext);
        tick();
    endtask

    task automatic test_bad_plaintext();
        bus.ctxt_ready = 1'b1;
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "#";
        tick();
        n_checks++;
        if ({bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
             bus.error_flag_plaintext} !== {1'b1, 16'h0000, 1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL bad_char: got valid=%b ct=%h ul=%b efk=%b efp=%b need 1 0000 0 0 1",
                     bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
                     bus.error_flag_plaintext);
        end
        bus.plaintext = "B";
        tick();
        bus.ptxt_valid = 1'b0;
        n_checks++;
        if ({bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
             bus.error_flag_plaintext} !== {1'b1, pair("a", "h"), 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL after_bad_B: got valid=%b ct=%h ul=%b efk=%b efp=%b need 1 %h 1 0 0",
                     bus.ctxt_valid, bus.ciphertext, bus.upper_lower, bus.error_flag_key,
                     bus.error_flag_plaintext, pair("a", "h"));
        end
        $display("# then B -> %h", bus.ciphertext);
        tick();
    endtask

    task automatic test_invalid_keys();
        string       keys [2];
        logic [7:0]  chars [2];
        logic [15:0] exp   [2];
        int          lat;
        keys[0] = "abcdefghiakl";
        keys[1] = "abc?efghijkl";
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
        chars[0] = "b"; exp[0] = 16'h0000;
        chars[1] = "b"; exp[1] = 16'h0000;
`else
        chars[0] = "b"; exp[0] = pair("a", "h");
        chars[1] = "x"; exp[1] = pair(8'h3F, "l");
`endif
        bus.ctxt_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            load_key(keys[k]);
            wait_ready(lat);
            n_checks++;
            if (lat != KEY_LAT) begin
                n_fail++;
                $display("FAIL bad_key_latency_%0d: got %0d need %0d", k, lat, KEY_LAT);
            end
`ifdef SUB_TABLE_ENC_KEY_CHECK_EN
            n_checks++;
            if ({bus.error_flag_key, bus.ctxt_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL key_err_level_%0d: got efk=%b valid=%b need 1 0",
                         k, bus.error_flag_key, bus.ctxt_valid);
            end
`endif
            bus.ptxt_valid = 1'b1;
            bus.plaintext  = chars[k];
            tick();
            bus.ptxt_valid = 1'b0;
            n_checks++;
            if ({bus.ctxt_valid, bus.ciphertext, bus.error_flag_key} !==
                {1'b1, exp[k], (KEY_LAT == 13)}) begin
                n_fail++;
                $display("FAIL bad_key_word_%0d: got valid=%b ct=%h efk=%b need 1 %h %b",
                         k, bus.ctxt_valid, bus.ciphertext, bus.error_flag_key, exp[k], KEY_LAT == 13);
            end
            $display("key %s: %c -> %h efk=%b", keys[k], chars[k], bus.ciphertext, bus.error_flag_key);
            tick();
        end
    endtask

    task automatic test_abort();
        int lat;
        load_key("abcdefghijkl");
        wait_ready(lat);
        bus.ctxt_ready = 1'b0;
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "a";
        tick();
        bus.ptxt_valid = 1'b0;
        load_key("abcdefghiakl");
        n_checks++;
        if (bus.ctxt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL key_write_discard: ctxt_valid got %b need 0", bus.ctxt_valid);
        end
        bus.ctxt_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.key_byte_val = 1'b1;
        bus.byte_pos     = 4'd9;
        bus.key_byte     = "j";
        tick();
        bus.key_byte_val = 1'b0;
        wait_ready(lat);
        n_checks++;
        if (lat != KEY_LAT || bus.error_flag_key !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recheck: got lat=%0d efk=%b need %0d 0", lat, bus.error_flag_key, KEY_LAT);
        end
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "J";
        tick();
        bus.ptxt_valid = 1'b0;
        n_checks++;
        if ({bus.ciphertext, bus.upper_lower} !== {pair("b", "j"), 1'b1}) begin
            n_fail++;
            $display("FAIL abort_J: got ct=%h ul=%b need %h 1", bus.ciphertext, bus.upper_lower, pair("b", "j"));
        end
        $display("abort: J -> %h", bus.ciphertext);
    endtask

    task automatic test_reset_mid();
        bus.ctxt_ready = 1'b1;
        bus.ptxt_valid = 1'b1;
        bus.plaintext  = "Z";
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ptxt_ready, bus.ctxt_valid, bus.ciphertext, bus.upper_lower,
             bus.error_flag_key, bus.error_flag_plaintext} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ready=%b valid=%b ct=%h ul=%b need all 0",
                     bus.ptxt_ready, bus.ctxt_valid, bus.ciphertext, bus.upper_lower);
        end
        bus.ptxt_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        n_checks++;
        if ({bus.ptxt_ready, bus.ctxt_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_empty: got ready=%b valid=%b need 0 0", bus.ptxt_ready, bus.ctxt_valid);
        end
        $display("mid-stream reset: ready=%b valid=%b", bus.ptxt_ready, bus.ctxt_valid);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        bus.key_byte     = 8'h00;
        bus.byte_pos     = 4'd0;
        bus.key_byte_val = 1'b0;
        bus.ptxt_valid   = 1'b0;
        bus.plaintext    = 8'h00;
        bus.ctxt_ready   = 1'b0;
        test_reset();
        test_key_latency();
        test_upper();
        test_back_to_back();
        test_backpressure();
        test_bad_plaintext();
        test_invalid_keys();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
